// File: rtl/pbit_array.sv
// rtl/pbit_array.sv - array of LFSR-driven probabilistic bits with parallel/sequential update
module pbit_array #(
    parameter int          N       = 4,
    parameter int          A_W     = 8,
    parameter logic [7:0]  SEED_LO = 8'hA5,
    localparam int         IDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 mode,
    input  logic [N*A_W-1:0]     act,
    input  logic [2*N-1:0]       shift,
    output logic [N-1:0]         out,
    output logic                 upd_valid,
    output logic [IDX_W-1:0]     upd_idx,
    output logic                 sweep_done,
    output logic [15:0]          sweep_cnt
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic [15:0]      q [N];
    logic [A_W-1:0]   sh_now [N];
    logic [A_W-1:0]   s1_sh [N];
    logic             s1_valid;
    logic             s1_mode;
    logic [IDX_W-1:0] s1_idx;
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     cmp;
    logic             sweep_hit;

    // Left shifts clamp to all-ones instead of wrapping.
    function automatic logic [A_W-1:0] shift_act(input logic [A_W-1:0] a, input logic [1:0] c);
        logic [A_W+1:0] w;
        w = {2'b00, a};
        case (c)
            2'b00:   w = {2'b00, a};
            2'b01:   w = {2'b00, a} >> 1;
            2'b10:   w = {2'b00, a} << 1;
            default: w = {2'b00, a} << 2;
        endcase
        return (w[A_W+1:A_W] != 2'b00) ? {A_W{1'b1}} : w[A_W-1:0];
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            sh_now[i] = shift_act(act[i*A_W +: A_W], shift[2*i +: 2]);
            cmp[i]    = s1_sh[i] < q[i][A_W-1:0];
        end
        sweep_hit = s1_valid && (!s1_mode || (s1_idx == LAST));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out        <= '0;
            upd_valid  <= 1'b0;
            upd_idx    <= '0;
            sweep_done <= 1'b0;
            sweep_cnt  <= '0;
            idx        <= '0;
            s1_valid   <= 1'b0;
            s1_mode    <= 1'b0;
            s1_idx     <= '0;
            for (int i = 0; i < N; i++) begin
                q[i]     <= {8'(i), SEED_LO};
                s1_sh[i] <= '0;
            end
        end else begin
            upd_valid  <= 1'b0;
            sweep_done <= 1'b0;
            if (en) begin
                for (int i = 0; i < N; i++) begin
                    q[i]     <= lfsr_next(q[i]);
                    s1_sh[i] <= sh_now[i];
                end
                s1_valid <= 1'b1;
                s1_mode  <= mode;
                s1_idx   <= mode ? idx : '0;
                idx      <= (mode && idx != LAST) ? idx + 1'b1 : '0;
                // Stage 2 uses the mode captured with the item, not the live input.
                if (s1_valid) begin
                    upd_valid  <= 1'b1;
                    sweep_done <= sweep_hit;
                    if (!s1_mode) begin
                        out     <= cmp;
                        upd_idx <= '0;
                    end else begin
                        out[s1_idx] <= cmp[s1_idx];
                        upd_idx     <= s1_idx;
                    end
                    if (sweep_hit && sweep_cnt != 16'hFFFF)
                        sweep_cnt <= sweep_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pbit_array.sv
// tb/tb_pbit_array.sv - randomized scoreboard bench for pbit_array
module tb_pbit_array;
    localparam int N   = 4;
    localparam int A_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic [N*A_W-1:0] act = '0;
    logic [2*N-1:0]   shift = '0;
    logic [N-1:0]     out;
    logic             upd_valid;
    logic [1:0]       upd_idx;
    logic             sweep_done;
    logic [15:0]      sweep_cnt;

    always #5 clk = ~clk;

    pbit_array #(.N(N), .A_W(A_W), .SEED_LO(8'hA5)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .act(act), .shift(shift),
        .out(out), .upd_valid(upd_valid), .upd_idx(upd_idx),
        .sweep_done(sweep_done), .sweep_cnt(sweep_cnt)
    );

    typedef struct {
        logic [N-1:0] out;
        int           idx;
        bit           done;
        int           cnt;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    // Reference model: channel state as plain integers, one pending capture.
    int           mq [N];
    bit           pv;
    bit           pm;
    int           pidx;
    int           psh [N];
    int           midx;
    logic [N-1:0] mout;
    int           mcnt;

    function automatic int lfsr(input int v);
        int b;
        b = v[15] ^ v[13] ^ v[12] ^ v[10];
        return ((v * 2) % 65536) + b;
    endfunction

    function automatic int scaled(input int a, input int c);
        int v;
        case (c)
            0:       v = a;
            1:       v = a / 2;
            2:       v = a * 2;
            default: v = a * 4;
        endcase
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_edge();
        exp_t e;
        if (!reset) begin
            for (int i = 0; i < N; i++) mq[i] = i * 256 + 'hA5;
            pv = 0; pm = 0; pidx = 0; midx = 0; mout = '0; mcnt = 0;
        end else if (en) begin
            if (pv) begin
                if (!pm) begin
                    for (int i = 0; i < N; i++) mout[i] = (psh[i] < (mq[i] % 256));
                    e.idx = 0; e.done = 1;
                end else begin
                    mout[pidx] = (psh[pidx] < (mq[pidx] % 256));
                    e.idx = pidx; e.done = (pidx == N - 1);
                end
                if (e.done && mcnt < 65535) mcnt++;
                e.out = mout; e.cnt = mcnt;
                sbq.push_back(e);
            end
            pv = 1; pm = mode;
            pidx = mode ? midx : 0;
            midx = mode ? (midx + 1) % N : 0;
            for (int i = 0; i < N; i++) begin
                psh[i] = scaled(int'(act[i*A_W +: A_W]), int'(shift[2*i +: 2]));
                mq[i]  = lfsr(mq[i]);
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit m,
                        input logic [N*A_W-1:0] a, input logic [2*N-1:0] s);
        @(negedge clk);
        reset = r; en = e; mode = m; act = a; shift = s;
        model_edge();
    endtask

    function automatic logic [N*A_W-1:0] fill(input logic [A_W-1:0] v);
        return {N{v}};
    endfunction

    function automatic logic [N*A_W-1:0] rnd_act();
        logic [N*A_W-1:0] v;
        for (int i = 0; i < N; i++) v[i*A_W +: A_W] = A_W'($urandom);
        return v;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                check("rst_out", out, 0);
                check("rst_valid", upd_valid, 0);
                check("rst_idx", upd_idx, 0);
                check("rst_done", sweep_done, 0);
                check("rst_cnt", sweep_cnt, 0);
                sbq.delete();
            end else if (upd_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("out", out, e.out);
                    check("upd_idx", upd_idx, e.idx);
                    check("sweep_done", sweep_done, e.done);
                    check("sweep_cnt", sweep_cnt, e.cnt);
                end
            end else begin
                check("idle_done", sweep_done, 0);
                if (sbq.size() != 0) begin
                    check("missing_write", 0, 1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin : driver
        for (int k = 0; k < 3; k++) step(0, 1, 0, '0, '0);
        // Saturated activations never fire.
        for (int k = 0; k < 20; k++) step(1, 1, 0, fill(8'hFF), '0);
        for (int k = 0; k < 10; k++) step(1, 1, 0, fill(8'h40), 8'hFF);
        for (int k = 0; k < 10; k++) step(1, 1, 0, fill(8'h40), 8'hAA);
        // Sequential sweeps from a cold start.
        step(0, 0, 0, '0, '0);
        for (int k = 0; k < 12; k++) step(1, 1, 1, rnd_act(), 8'($urandom));
        for (int k = 0; k < 12; k++) step(1, (k % 4 == 0) || (k % 4 == 3), 1, rnd_act(), 8'($urandom));
        // Reset while stage 1 holds a capture.
        step(1, 1, 1, rnd_act(), 8'($urandom));
        step(0, 1, 1, rnd_act(), 8'($urandom));
        for (int k = 0; k < 8; k++) step(1, 1, 0, fill(8'h40), 8'hAA);
        for (int k = 0; k < 3000; k++)
            step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 9) < 8),
                 1'($urandom), rnd_act(), 8'($urandom));
        // Drive enough parallel sweeps to reach saturation, then a few more.
        step(0, 0, 0, '0, '0);
        for (int k = 0; k < 65540; k++) step(1, 1, 0, rnd_act(), 8'($urandom));
        step(1, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        @(negedge clk);
        check("sat_cnt", sweep_cnt, 16'hFFFF);
        check("queue_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pbit_array.md
PBIT_ARRAY -- requirements
Module: pbit_array

Interface
REQ-001 Parameter N, default 4, number of p-bit channels (1..256).
REQ-002 Parameter A_W, default 8, activation and compare width (2..16).
REQ-003 Parameter SEED_LO, default 8'hA5, low byte of every channel LFSR seed (nonzero).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 en  input  1  advance enable; 0 stalls the whole block.
REQ-007 mode  input  1  0 = parallel update of all channels, 1 = sequential (one channel per enabled cycle).
REQ-008 act  input  N*A_W  activation per channel; channel i at bits [i*A_W +: A_W].
REQ-009 shift  input  2*N  shift code per channel; channel i at bits [2i +: 2].
REQ-010 out  output  N  registered p-bit states.
REQ-011 upd_valid  output  1  one-cycle pulse when out is written.
REQ-012 upd_idx  output  clog2(N) (min 1)  channel written (sequential); 0 in parallel.
REQ-013 sweep_done  output  1  one-cycle pulse at completion of a full sweep.
REQ-014 sweep_cnt  output  16  count of completed sweeps, saturating.

Function
REQ-015 Each channel i SHALL own a 16-bit Fibonacci LFSR q_i; next = {q_i[14:0], q_i[15]^q_i[13]^q_i[12]^q_i[10]}; seed = {i[7:0], SEED_LO}.
REQ-016 All LFSRs SHALL advance exactly once per cycle with en=1, in both modes; they SHALL hold when en=0.
REQ-017 Random value r_i SHALL be q_i[A_W-1:0], taken at the stage-2 cycle.
REQ-018 Shift codes: 00 = a; 01 = a>>1; 10 = a<<1; 11 = a<<2; left shifts SHALL saturate to all-ones on overflow of A_W bits.
REQ-019 Stage 1 (en=1): register shifted activation(s), captured mode, target index, stage-1 valid.
REQ-020 Stage 2 (en=1, stage-1 valid): out_i <= (shifted_i < r_i) ? 1 : 0, unsigned compare, A_W bits.
REQ-021 Latency: act/shift sampled at enabled edge t SHALL appear on out after enabled edge t+1 (2 enabled cycles).
REQ-022 Parallel mode: all N channels captured and written together; upd_idx = 0; sweep_done pulses with each write.
REQ-023 Sequential mode: index counter idx selects channel captured at stage 1, increments per enabled cycle, wraps N-1 -> 0; only out[idx] written; other bits hold.
REQ-024 Sequential: upd_idx = index written; sweep_done pulses when index N-1 is written.
REQ-025 Stage-1 capture in parallel mode SHALL clear idx to 0; switching to sequential starts at channel 0.
REQ-026 Mode change: in-flight stage-2 item SHALL complete under its captured mode; new mode applies from next capture.
REQ-027 en=0: no capture, no write, upd_valid=0, sweep_done=0, idx/pipeline/LFSRs hold; resume continues exactly where stalled.
REQ-028 sweep_cnt increments on sweep_done; SHALL saturate at 16'hFFFF.
REQ-029 N=1: sequential behaves as parallel except upd_idx=0 always.

Reset
REQ-030 reset=0 at a clock edge SHALL set out=0, upd_valid=0, upd_idx=0, sweep_done=0, sweep_cnt=0, idx=0, stage-1 valid=0, q_i=seed_i.
REQ-031 Reset SHALL override en; in-flight captures are discarded and never written.
REQ-032 First enabled edge after reset release SHALL capture; first upd_valid SHALL follow on the next enabled edge.

Verification
REQ-033 Reset then parallel, en=1, all act=8'hFF, shift=00 -> out=0 every write, upd_valid high from 2nd cycle, sweep_cnt counts 1,2,3...
REQ-034 Parallel, act=8'h40, shift=11 -> saturates to 8'hFF, out stays 0; act=8'h40 shift=10 -> 8'h80, out matches golden LFSR model bit-exact.
REQ-035 Sequential, N=4, en=1 for 12 cycles -> upd_idx 0,1,2,3,0..., sweep_done on each idx 3, sweep_cnt=2 after 10 enabled cycles post-reset; untouched bits hold.
REQ-036 Toggle en 1,0,0,1 mid-sweep -> no pulses during stall, LFSR/idx frozen, sequence resumes identical to en-always-1 run shifted by 2 cycles.
REQ-037 Assert reset while stage 1 holds a capture -> no write follows, all outputs zero, LFSRs back to seeds; post-reset output stream identical to cold start.
REQ-038 Force sweep_cnt to 16'hFFFE, run 3 sweeps -> sweep_cnt stays 16'hFFFF.
